// File: rtl/dmem_line_responder.sv
// Line-granular data memory responder: accepts one whole-line read or write
// in IDLE, waits LATENCY clock edges, then strobes ack_o for a single cycle.
module dmem_line_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    localparam int       LINES  = 1 << DEPTH_LOG2;
    localparam int       IDX_HI = DEPTH_LOG2 + 4;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [255:0]            wdata_q, wdata_d;

    logic [255:0]            mem_q [LINES];

    // Offset bits and address bits above the line index are dropped, so
    // out-of-range line addresses alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_HI+1], addr_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_M1;
                    idx_d   = addr_i[IDX_HI:5];
                    wr_d    = write_i;
                    wdata_d = data_i;
                end
            end
            ST_WAIT: begin
                // A requester dropping enable_i mid-wait abandons the request.
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory is deliberately not reset; writes commit on the edge leaving ACK.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_ACK && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = (state_q == ST_ACK);
    assign busy_o = (state_q != ST_IDLE);
    assign data_o = (state_q == ST_ACK && !wr_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: one instance at LATENCY=10 and one
// at LATENCY=1 for the back-to-back ack spacing case.
module tb_dmem_line_responder;

    logic         clk;
    logic         rst;

    logic         en_a, wr_a, ack_a, busy_a;
    logic [31:0]  addr_a;
    logic [255:0] din_a, dout_a;

    logic         en_b, wr_b, ack_b, busy_b;
    logic [31:0]  addr_b;
    logic [255:0] din_b, dout_b;

    int errors = 0;
    int checks = 0;

    dmem_line_responder #(.LATENCY(10), .DEPTH_LOG2(9)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .write_i(wr_a),
        .addr_i(addr_a), .data_i(din_a), .ack_o(ack_a), .data_o(dout_a),
        .busy_o(busy_a)
    );

    dmem_line_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr_b),
        .addr_i(addr_b), .data_i(din_b), .ack_o(ack_b), .data_o(dout_b),
        .busy_o(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Issues one request on dut_a, returns edges from acceptance to ack and
    // the data seen in the ack cycle; quiet_ok flags any data_o/busy_o
    // glitch before the ack or any leftover activity after it.
    task automatic req_a(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                         output int lat, output logic [255:0] rdata, output logic quiet_ok);
        @(negedge clk);
        en_a = 1'b1; wr_a = wr; addr_a = addr; din_a = d;
        @(posedge clk); #1;
        lat = 0; quiet_ok = 1'b1; rdata = '0;
        while (!ack_a && lat < 300) begin
            if (dout_a !== '0 || busy_a !== 1'b1) quiet_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rdata = dout_a;
        en_a = 1'b0;
        @(posedge clk); #1;
        if (ack_a !== 1'b0 || dout_a !== '0 || busy_a !== 1'b0) quiet_ok = 1'b0;
    endtask

    logic [255:0] pat_a5, rd;
    logic [255:0] line5_init, line2_init, wrap_data, p10, p11, d1, d4;
    logic         quiet, saw_ack;
    logic [4:0]   ack_h, busy_h;
    int           lat;

    initial begin
        pat_a5     = {32{8'hA5}};
        line5_init = {8{32'h5555_0005}};
        line2_init = {8{32'h2222_0002}};
        wrap_data  = {4{64'hCAFE_F00D_0BAD_BEEF}};
        p10        = {16{16'h1010}};
        p11        = {16{16'h1111}};

        rst = 1'b0;
        en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;

        dut_a.mem_q[3] = pat_a5;
        dut_a.mem_q[5] = line5_init;
        dut_a.mem_q[2] = line2_init;
        dut_b.mem_q[10] = p10;
        dut_b.mem_q[11] = p11;

        #12;
        check("reset_ack",  256'(ack_a),  256'd0);
        check("reset_busy", 256'(busy_a), 256'd0);
        check("reset_data", dout_a,       256'd0);
        check("reset_b_busy", 256'(busy_b), 256'd0);
        @(negedge clk);
        rst = 1'b1;

        // Plain read of line 3.
        req_a(1'b0, 32'h60, '0, lat, rd, quiet);
        check("rd3_latency", 256'(lat), 256'd10);
        check("rd3_data",    rd,        pat_a5);
        check("rd3_quiet",   256'(quiet), 256'd1);

        // Write line 7, then read it back via an unaligned byte address.
        req_a(1'b1, 32'hE0, 256'h1234, lat, rd, quiet);
        check("wr7_latency", 256'(lat), 256'd10);
        check("wr7_data_zero", rd, 256'd0);
        req_a(1'b0, 32'hE4, '0, lat, rd, quiet);
        check("rd7_latency", 256'(lat), 256'd10);
        check("rd7_data",    rd,        256'h1234);

        // Abort a write to line 5 after four cycles.
        @(negedge clk);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'hA0; din_a = 256'hDEAD;
        repeat (4) @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        saw_ack = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ack_a) saw_ack = 1'b1;
        end
        check("abort_no_ack", 256'(saw_ack), 256'd0);
        check("abort_busy",   256'(busy_a),  256'd0);
        check("abort_mem5",   dut_a.mem_q[5], line5_init);
        req_a(1'b0, 32'hA0, '0, lat, rd, quiet);
        check("abort_next_latency", 256'(lat), 256'd10);
        check("abort_next_data",    rd,        line5_init);

        // High address bits alias onto line 1.
        req_a(1'b1, 32'h4000_0020, wrap_data, lat, rd, quiet);
        check("wrap_mem1", dut_a.mem_q[1], wrap_data);
        req_a(1'b0, 32'h20, '0, lat, rd, quiet);
        check("wrap_rd_data", rd, wrap_data);

        // Reset during the wait phase of a write to line 2.
        @(negedge clk);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h40; din_a = 256'hBAD2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en_a = 1'b0;
        #1;
        check("rst_mid_ack",  256'(ack_a),  256'd0);
        check("rst_mid_busy", 256'(busy_a), 256'd0);
        check("rst_mid_data", dout_a,       256'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_mem2", dut_a.mem_q[2], line2_init);
        req_a(1'b0, 32'h40, '0, lat, rd, quiet);
        check("rst_after_latency", 256'(lat), 256'd10);
        check("rst_after_data",    rd,        line2_init);

        // LATENCY=1 with enable held across the ack: lines 10 then 11.
        @(negedge clk);
        en_b = 1'b1; wr_b = 1'b0; addr_b = 32'h140;
        d1 = '0; d4 = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ack_h[i]  = ack_b;
            busy_h[i] = busy_b;
            if (i == 1) d1 = dout_b;
            if (i == 4) d4 = dout_b;
            if (i == 2) addr_b = 32'h160;
        end
        en_b = 1'b0;
        check("b2b_ack_pattern",  256'(ack_h),  256'(5'b10010));
        check("b2b_busy_pattern", 256'(busy_h), 256'(5'b11011));
        check("b2b_data_line10",  d1, p10);
        check("b2b_data_line11",  d4, p11);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
